// File: rtl/cpu_run_sequencer.sv
// CPU run sequencer: preloads the mailbox, releases CPU reset, captures
// node-point stores into a FIFO and ends the run on DONE or timeout.
module cpu_run_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] TIMEOUT    = 32'd100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [4:0]                    start_point,
  input  logic [4:0]                    end_point,
  output logic                          cpu_reset,
  output logic                          ext_memwrite,
  output logic [31:0]                   ext_writedata,
  output logic [31:0]                   ext_dataadr,
  input  logic                          cpu_memwrite,
  input  logic [31:0]                   cpu_writedata,
  input  logic [31:0]                   cpu_dataadr,
  input  logic                          node_rd,
  output logic [31:0]                   node_dout,
  output logic                          node_empty,
  output logic [$clog2(FIFO_DEPTH):0]   node_count,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FINISH,
    S_ABORT
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [31:0]    r_cnt;
  logic [4:0]     r_sp;
  logic [4:0]     r_ep;
  logic [31:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wp;
  logic [AW-1:0]  r_rp;
  logic [CW-1:0]  r_count;

  logic w_start_ok;
  logic w_in_run;
  logic w_node_wr;
  logic w_done_wr;
  logic w_last;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_flush;

  assign w_start_ok = start &&
                      (r_state == S_IDLE ||
                       r_state == S_FINISH ||
                       r_state == S_ABORT);
  assign w_in_run  = (r_state == S_RUN);
  assign w_node_wr = w_in_run && cpu_memwrite &&
                     (cpu_dataadr == BASE_ADDR + 32'd8);
  assign w_done_wr = w_in_run && cpu_memwrite &&
                     (cpu_dataadr == BASE_ADDR + 32'd12) &&
                     (cpu_writedata == 32'd1);
  assign w_last    = w_in_run && (r_cnt == TIMEOUT - 32'd1);

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = node_rd && (r_count != '0);
  // A full FIFO still accepts a push when the same cycle frees a slot
  assign w_push  = w_node_wr && (!w_full || w_pop);
  assign w_flush = reset || w_start_ok;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_FINISH, S_ABORT:
        if (w_start_ok) w_next = S_LOAD;
      S_LOAD:
        if (r_cnt == 32'd7) w_next = S_RUN;
      S_RUN:
        if (w_done_wr)   w_next = S_FINISH;
        else if (w_last) w_next = S_ABORT;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Shared phase counter: LOAD slot index, then RUN cycle index
  always_ff @(posedge clk) begin
    if (reset)                 r_cnt <= '0;
    else if (r_state != w_next) r_cnt <= '0;
    else if (busy)             r_cnt <= r_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
      r_ep <= '0;
    end else if (w_start_ok) begin
      r_sp <= start_point;
      r_ep <= end_point;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (w_done_wr)   done    <= 1'b1;
      else if (w_last) timeout <= 1'b1;
      if (w_node_wr && w_full && !w_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= cpu_writedata;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign node_dout  = r_mem[r_rp];
  assign node_empty = (r_count == '0);
  assign node_count = r_count;
  assign busy       = (r_state == S_LOAD) || (r_state == S_RUN);
  assign cpu_reset  = !w_in_run;

  always_comb begin
    ext_memwrite  = 1'b0;
    ext_writedata = '0;
    ext_dataadr   = '0;
    if (r_state == S_LOAD && !r_cnt[0]) begin
      ext_memwrite = 1'b1;
      ext_dataadr  = BASE_ADDR + {28'd0, r_cnt[2:1], 2'b00};
      unique case (r_cnt[2:1])
        2'd0:    ext_writedata = {27'd0, r_sp};
        2'd1:    ext_writedata = {27'd0, r_ep};
        default: ext_writedata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cpu_run_sequencer;

  localparam int          DEPTH = 4;
  localparam int          TO    = 20;
  localparam logic [31:0] BASE  = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset, start, cpu_memwrite, node_rd;
  logic [4:0]  start_point, end_point;
  logic [31:0] cpu_writedata, cpu_dataadr;
  logic        cpu_reset, ext_memwrite, node_empty;
  logic [31:0] ext_writedata, ext_dataadr, node_dout;
  logic [2:0]  node_count;
  logic        busy, done, timeout, overflow;

  int tests = 0;
  int fails = 0;

  cpu_run_sequencer #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (32'(TO))
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_point(start_point), .end_point(end_point),
    .cpu_reset(cpu_reset), .ext_memwrite(ext_memwrite),
    .ext_writedata(ext_writedata), .ext_dataadr(ext_dataadr),
    .cpu_memwrite(cpu_memwrite), .cpu_writedata(cpu_writedata),
    .cpu_dataadr(cpu_dataadr), .node_rd(node_rd),
    .node_dout(node_dout), .node_empty(node_empty),
    .node_count(node_count), .busy(busy), .done(done),
    .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_FIN, M_ABT} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_k = 0;
  int         m_q[$];
  bit         m_done, m_to, m_ovf;
  logic [4:0] m_sp, m_ep;
  bit         armed = 0;

  always @(posedge clk) begin
    bit pop;
    if (reset) begin
      m_mode = M_IDLE; m_k = 0; m_q.delete();
      m_done = 0; m_to = 0; m_ovf = 0;
      m_sp = '0; m_ep = '0; armed = 1;
    end else begin
      pop = node_rd && (m_q.size() > 0);
      case (m_mode)
        M_IDLE, M_FIN, M_ABT: begin
          if (start) begin
            m_sp = start_point; m_ep = end_point;
            m_q.delete();
            m_done = 0; m_to = 0; m_ovf = 0;
            m_mode = M_LOAD; m_k = 0;
          end else if (pop) void'(m_q.pop_front());
        end
        M_LOAD: begin
          if (pop) void'(m_q.pop_front());
          m_k++;
          if (m_k == 8) begin m_mode = M_RUN; m_k = 0; end
        end
        M_RUN: begin
          if (pop) void'(m_q.pop_front());
          if (cpu_memwrite && cpu_dataadr == BASE + 8) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(cpu_writedata));
            else m_ovf = 1;
          end
          if (cpu_memwrite && cpu_dataadr == BASE + 12 &&
              cpu_writedata == 1) begin
            m_mode = M_FIN; m_done = 1;
          end else if (m_k == TO - 1) begin
            m_mode = M_ABT; m_to = 1;
          end else m_k++;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    bit          wr;
    logic [31:0] ea, ed;
    if (armed) begin
      wr = (m_mode == M_LOAD) && (m_k % 2 == 0);
      ea = wr ? BASE + 32'(4 * (m_k / 2)) : 32'd0;
      ed = !wr ? 32'd0 :
           (m_k == 0) ? 32'(m_sp) :
           (m_k == 2) ? 32'(m_ep) : 32'd0;
      chk("m_cpu_reset", 32'(cpu_reset), 32'(m_mode != M_RUN));
      chk("m_memwrite", 32'(ext_memwrite), 32'(wr));
      chk("m_dataadr", ext_dataadr, ea);
      chk("m_writedata", ext_writedata, ed);
      chk("m_busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_RUN));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_timeout", 32'(timeout), 32'(m_to));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_count", 32'(node_count), 32'(m_q.size()));
      chk("m_empty", 32'(node_empty), 32'(m_q.size() == 0));
      if (m_q.size() > 0) chk("m_dout", node_dout, 32'(m_q[0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] sp, input logic [4:0] ep);
    start = 1; start_point = sp; end_point = ep;
    tick();
    start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = 1; cpu_dataadr = a; cpu_writedata = d;
    tick();
    cpu_memwrite = 0; cpu_dataadr = '0; cpu_writedata = '0;
  endtask

  task automatic pop1();
    node_rd = 1;
    tick();
    node_rd = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] at[8];
    logic [31:0] dt[8];
    logic [7:0]  mw;
    int          n;
    int          exp_pop[3];

    reset = 1; start = 0; start_point = '0; end_point = '0;
    cpu_memwrite = 0; cpu_writedata = '0; cpu_dataadr = '0;
    node_rd = 0;
    repeat (2) tick();
    #3;
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_memwrite", 32'(ext_memwrite), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(node_empty), 1);
    chk("rst_count", 32'(node_count), 0);
    reset = 0;
    tick();

    // mailbox preload
    at = '{32'h0200_0000, 0, 32'h0200_0004, 0,
           32'h0200_0008, 0, 32'h0200_000C, 0};
    dt = '{3, 0, 11, 0, 0, 0, 0, 0};
    mw = 8'b0101_0101;
    do_start(5'd3, 5'd11);
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("load_adr", ext_dataadr, at[k]);
      chk("load_data", ext_writedata, dt[k]);
      chk("load_we", 32'(ext_memwrite), 32'(mw[k]));
      chk("load_cpu_reset", 32'(cpu_reset), 1);
      tick();
    end
    #3;
    chk("run_cpu_reset", 32'(cpu_reset), 0);
    chk("run_busy", 32'(busy), 1);

    // node stores, ignored stores, ignored start, then DONE
    store(BASE + 8, 3);
    store(BASE + 8, 7);
    store(BASE + 16, 99);
    store(BASE + 8, 11);
    store(BASE + 12, 2);
    start = 1; tick(); start = 0;
    #3;
    chk("start_in_run_busy", 32'(busy), 1);
    chk("start_in_run_cpu_reset", 32'(cpu_reset), 0);
    store(BASE + 12, 1);
    #3;
    chk("fin_done", 32'(done), 1);
    chk("fin_cpu_reset", 32'(cpu_reset), 1);
    chk("fin_count", 32'(node_count), 3);
    chk("fin_busy", 32'(busy), 0);
    exp_pop = '{3, 7, 11};
    for (int i = 0; i < 3; i++) begin
      chk("pop_val", node_dout, 32'(exp_pop[i]));
      pop1();
      #3;
    end
    chk("pop_empty", 32'(node_empty), 1);
    pop1();
    #3;
    chk("pop_empty_count", 32'(node_count), 0);

    // timeout
    do_start(5'd1, 5'd2);
    repeat (8) tick();
    n = 0;
    while (!cpu_reset && n < 100) begin
      tick();
      n++;
    end
    chk("run_cycles", 32'(n), 20);
    #3;
    chk("to_timeout", 32'(timeout), 1);
    chk("to_done", 32'(done), 0);
    chk("to_cpu_reset", 32'(cpu_reset), 1);

    // overflow, order retention, flush overriding pop
    do_start(5'd4, 5'd5);
    repeat (8) tick();
    for (int i = 0; i < 5; i++) store(BASE + 8, 32'(10 + i));
    store(BASE + 12, 1);
    #3;
    chk("ovf_count", 32'(node_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_pop", node_dout, 32'(10 + i));
      pop1();
      #3;
    end
    chk("ovf_last", node_dout, 32'd13);
    start = 1; node_rd = 1; start_point = 5'd9; end_point = 5'd10;
    tick();
    start = 0; node_rd = 0;
    #3;
    chk("flush_count", 32'(node_count), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_done", 32'(done), 0);

    // reset mid-RUN, reset beats start
    repeat (8) tick();
    start = 1; tick(); start = 0;
    repeat (2) tick();
    #3;
    chk("mid_run_busy", 32'(busy), 1);
    reset = 1; tick(); reset = 0;
    #3;
    chk("mr_cpu_reset", 32'(cpu_reset), 1);
    chk("mr_memwrite", 32'(ext_memwrite), 0);
    chk("mr_wdata", ext_writedata, 0);
    chk("mr_adr", ext_dataadr, 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_flags", {done, timeout, overflow}, 0);
    chk("mr_count", 32'(node_count), 0);
    chk("mr_empty", 32'(node_empty), 1);
    reset = 1; start = 1; tick(); reset = 0; start = 0;
    #3;
    chk("rst_over_start", 32'(busy), 0);

    // DONE on the final allowed RUN cycle
    do_start(5'd7, 5'd8);
    repeat (8) tick();
    repeat (TO - 1) tick();
    store(BASE + 12, 1);
    #3;
    chk("edge_done", 32'(done), 1);
    chk("edge_timeout", 32'(timeout), 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 150) == 0;
      start = ($urandom % 25) == 0;
      start_point = 5'($urandom);
      end_point = 5'($urandom);
      cpu_memwrite = ($urandom % 3) == 0;
      case ($urandom % 4)
        0: cpu_dataadr = BASE + 8;
        1: cpu_dataadr = BASE + 12;
        2: cpu_dataadr = BASE;
        default: cpu_dataadr = $urandom;
      endcase
      cpu_writedata = (($urandom % 3) == 0) ? 32'd1 : 32'($urandom % 64);
      node_rd = ($urandom % 4) == 0;
      tick();
    end
    reset = 0; start = 0; cpu_memwrite = 0; node_rd = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
